// File: rtl/mdu_pipelined.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// The result is computed at acceptance and held until the latency counter expires.
module mdu_pipelined #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             state_o
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] hi_p_q, lo_p_q;
   logic             wr_p_q;

   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0]   abs_a, abs_b, sdiv_b, udiv_b;
   logic [WIDTH-1:0]   smag_q, smag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;

   // Sign-extending to 2*WIDTH makes the truncated unsigned product the signed product.
   assign prod_s = {{WIDTH{operand_a[WIDTH-1]}}, operand_a} *
                   {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
   assign prod_u = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};

   // Signed divide works on magnitudes; a zero divisor is swapped for 1 and the
   // result is discarded at completion, so the divider never sees zero.
   assign abs_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
   assign abs_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;
   assign sdiv_b = (abs_b == '0) ? WIDTH'(1) : abs_b;
   assign udiv_b = (operand_b == '0) ? WIDTH'(1) : operand_b;
   assign smag_q = abs_a / sdiv_b;
   assign smag_r = abs_a % sdiv_b;
   assign sdiv_q = (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]) ? -smag_q : smag_q;
   assign sdiv_r = operand_a[WIDTH-1] ? -smag_r : smag_r;
   assign udiv_q = operand_a / udiv_b;
   assign udiv_r = operand_a % udiv_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         hi_p_q  <= '0;
         lo_p_q  <= '0;
         wr_p_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !cancel) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        hi_p_q  <= (op == OP_MULT) ? prod_s[2*WIDTH-1:WIDTH] : prod_u[2*WIDTH-1:WIDTH];
                        lo_p_q  <= (op == OP_MULT) ? prod_s[WIDTH-1:0] : prod_u[WIDTH-1:0];
                        wr_p_q  <= 1'b1;
                        cnt_q   <= CNT_W'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        hi_p_q  <= (op == OP_DIV) ? sdiv_r : udiv_r;
                        lo_p_q  <= (op == OP_DIV) ? sdiv_q : udiv_q;
                        wr_p_q  <= (operand_b != '0);
                        cnt_q   <= CNT_W'(DIV_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                     end
                     OP_MTHI: hi_q <= operand_a;
                     OP_MTLO: lo_q <= operand_a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               // Cancel outranks completion, even on the final busy cycle.
               if (cancel) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  wr_p_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (cnt_q == CNT_W'(1)) begin
                  if (wr_p_q) begin
                     hi_q <= hi_p_q;
                     lo_q <= lo_p_q;
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  wr_p_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign state_o = (state_q == RUN);

endmodule

// File: tb/tb_mdu_pipelined.sv
// Directed and randomised checks of mdu_pipelined: a 32-bit default instance
// and a 16-bit single-cycle instance checked against a language-level model.
module tb_mdu_pipelined;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, cancel;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, state;
   logic [31:0] hi, lo;

   logic        start2, cancel2;
   logic [2:0]  op2;
   logic [15:0] a2, b2;
   logic        busy2, state2;
   logic [15:0] hi2, lo2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdu_pipelined dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(a), .operand_b(b), .cancel(cancel),
      .busy(busy), .hi(hi), .lo(lo), .state_o(state)
   );

   mdu_pipelined #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(2)) dut16 (
      .clk(clk), .reset(reset), .start(start2), .op(op2),
      .operand_a(a2), .operand_b(b2), .cancel(cancel2),
      .busy(busy2), .hi(hi2), .lo(lo2), .state_o(state2)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          cyc;
      logic [15:0] m_hi, m_lo;
      longint      sa, sb, ua, ub, p, q, r;
      logic [63:0] pv, qv, rv;

      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      start2 = 1'b0; cancel2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;

      vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
      vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, "multu"};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
      vecs[3]  = '{3'd4, 32'h00000011, 32'd0,        0,  32'h00000011, 32'hFFFFFFFD, "mthi"};
      vecs[4]  = '{3'd5, 32'h00000022, 32'd0,        0,  32'h00000011, 32'h00000022, "mtlo"};
      vecs[5]  = '{3'd3, 32'h00000007, 32'd0,        10, 32'h00000011, 32'h00000022, "divu_by0"};
      vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf"};
      vecs[7]  = '{3'd3, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E, "divu"};
      vecs[8]  = '{3'd0, 32'd6,        32'd7,        5,  32'h00000000, 32'h0000002A, "mult_pos"};
      vecs[9]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negb"};
      vecs[10] = '{3'd6, 32'hDEADBEEF, 32'hBEEF,     0,  32'h00000001, 32'hFFFFFFFD, "reserved"};
      vecs[11] = '{3'd5, 32'h00001234, 32'd0,        0,  32'h00000001, 32'h00001234, "mtlo_1234"};

      do_reset();
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_state", {31'd0, state}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(cyc);
         check({vecs[i].name, "_cycles"}, cyc, vecs[i].cyc);
         check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
         check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      end

      // Cancel on the 3rd busy cycle.
      do_reset();
      issue(3'd0, 32'd6, 32'd7);
      repeat (2) @(negedge clk);
      check("cancel3_busy_before", {31'd0, busy}, 32'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel3_busy_after", {31'd0, busy}, 32'd0);
      repeat (6) @(negedge clk);
      check("cancel3_lo", lo, 32'd0);
      check("cancel3_hi", hi, 32'd0);

      // Cancel on the final (5th) busy cycle.
      issue(3'd0, 32'd6, 32'd7);
      repeat (4) @(negedge clk);
      check("cancel5_busy_before", {31'd0, busy}, 32'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel5_busy_after", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("cancel5_lo", lo, 32'd0);

      // Start while busy is ignored; then a back-to-back start right after busy falls.
      issue(3'd0, 32'd6, 32'd7);
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd100;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      check("interlock_cycles", cyc + 2, 32'd5);
      check("interlock_lo", lo, 32'd42);
      check("interlock_hi", hi, 32'd0);
      issue(3'd0, 32'd3, 32'd5);
      check("b2b_state", {31'd0, state}, 32'd1);
      wait_done(cyc);
      check("b2b_cycles", cyc, 32'd5);
      check("b2b_lo", lo, 32'd15);

      // Asynchronous reset in the middle of a divide.
      issue(3'd4, 32'h55, 32'd0);
      issue(3'd5, 32'h66, 32'd0);
      check("preset_hi", hi, 32'h55);
      issue(3'd2, 32'd100, 32'd3);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_hi", hi, 32'd0);
      check("async_lo", lo, 32'd0);
      check("async_state", {31'd0, state}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("post_reset_lo", lo, 32'd0);

      // 16-bit single-cycle instance against the reference model.
      m_hi = '0;
      m_lo = '0;
      for (int i = 0; i < 1000; i++) begin
         op2 = 3'($urandom_range(0, 3));
         a2  = 16'($urandom);
         b2  = 16'($urandom);
         if (i % 50 == 0) b2 = 16'h0000;
         if (i % 50 == 25) begin a2 = 16'h8000; b2 = 16'hFFFF; op2 = 3'd2; end
         sa = longint'($signed(a2));
         sb = longint'($signed(b2));
         ua = longint'(a2);
         ub = longint'(b2);
         case (op2)
            3'd0: begin p = sa * sb; pv = p; m_hi = pv[31:16]; m_lo = pv[15:0]; end
            3'd1: begin p = ua * ub; pv = p; m_hi = pv[31:16]; m_lo = pv[15:0]; end
            3'd2: if (b2 != 0) begin
               q = sa / sb; r = sa % sb; qv = q; rv = r; m_lo = qv[15:0]; m_hi = rv[15:0];
            end
            default: if (b2 != 0) begin
               q = ua / ub; r = ua % ub; qv = q; rv = r; m_lo = qv[15:0]; m_hi = rv[15:0];
            end
         endcase
         start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         check("w16_busy_on", {31'd0, busy2}, 32'd1);
         @(negedge clk);
         check("w16_busy_off", {31'd0, busy2}, 32'd0);
         check("w16_hi", {16'd0, hi2}, {16'd0, m_hi});
         check("w16_lo", {16'd0, lo2}, {16'd0, m_lo});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_pipelined.md
Name: mdu_pipelined

Overview:
- Parametrised multiply/divide unit with HI/LO registers, placed in the E stage of the five-stage pipeline.
- Executes mult, multu, div and divu with a configurable multi-cycle latency, and mthi/mtlo in a single cycle.
- Exposes `busy` so the hazard controller can stall later HI/LO instructions (mfhi, mflo, md ops) in D.
- Supports `cancel`, which aborts an in-flight operation on an exception flush.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is an MDU op this cycle.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (treated as no-op).
- operand_a  input  WIDTH  forwarded rs value.
- operand_b  input  WIDTH  forwarded rt value.
- cancel  input  1  flush; aborts an in-flight op and blocks any start in the same cycle.
- busy  output  1  registered; high while a mult/div is in flight.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, internal counter=0, pending result cleared. The next cycle behaves as idle.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter>0.
- Accept rule: a start is accepted iff start=1, busy=0 and cancel=0.
  - start while busy=1 is ignored. The hazard controller guarantees this never happens; the bench asserts it.
- MULT/MULTU accepted at edge T0:
  - compute the 2*WIDTH-bit product (signed / unsigned);
  - latch {hi_p, lo_p} = {product[2W-1:W], product[W-1:0]} internally;
  - counter<=MULT_CYCLES, busy<=1.
- DIV/DIVU accepted:
  - lo_p = quotient, hi_p = remainder;
  - signed division truncates toward zero and the remainder takes the sign of the dividend;
  - counter<=DIV_CYCLES, busy<=1.
- Divide by zero: operation is still accepted and busy runs the full DIV_CYCLES, but hi/lo are left unchanged at completion.
- Signed overflow (-2^(W-1) / -1): lo=-2^(W-1), hi=0.
- RUN, each edge with cancel=0: counter decrements. At the edge where counter==1: hi<=hi_p, lo<=lo_p, busy<=0, counter<=0.
  - busy is therefore high for exactly the configured number of cycles after the accepting edge.
  - hi/lo update on the same edge that busy falls.
- During RUN, hi/lo hold their old values. The hazard controller must not read them; mfhi/mflo stall on start|busy.
- MTHI/MTLO accepted (busy=0, cancel=0): hi<=operand_a (or lo<=operand_a) at that edge, with no busy cycle.
- cancel=1:
  - in RUN: busy<=0 and counter<=0 next edge; hi/lo are not updated and the pending result is discarded;
  - in IDLE: any start that cycle is dropped.
  - Cancel has priority over completion in the same cycle, so a cancel on the final busy cycle leaves hi/lo unchanged.
- Completion and a new start in the same cycle cannot coincide, because busy=1 blocks the start. The earliest back-to-back start is the cycle after busy falls.
- Reserved op codes with start=1: no state change.
- Arithmetic uses full-width combinational multiply and divide, registered at acceptance. The latency is modelled purely by the counter.

Test Plan:
- Signed multiply: reset then MULT a=0xFFFFFFFE, b=3 -> busy=1 for exactly 5 cycles; on the edge busy falls, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply and signed divide:
  - MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
  - DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Edge-case divides:
  - DIVU a=7, b=0 with hi=0x11, lo=0x22 preset by MTHI/MTLO -> busy 10 cycles, hi/lo remain 0x11/0x22.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Cancel and async reset:
  - MULT 6*7, then cancel on the 3rd busy cycle -> busy drops next edge, lo unchanged (0).
  - Repeat with cancel on the 5th busy cycle -> lo unchanged.
  - Assert reset mid-DIV -> busy, hi and lo go to 0 immediately, without waiting for a clock edge.
- Busy interlock and back-to-back ops:
  - start=MULT while busy -> ignored; the result equals the first op.
  - MTLO 0x1234 with busy=0 -> lo=0x1234 the next cycle, busy stays 0.
  - New MULT issued the cycle after busy falls -> accepted.
- Parameter sweep: instantiate with MULT_CYCLES=1, DIV_CYCLES=1 and with WIDTH=16 -> busy lasts 1 cycle; 16-bit signed and unsigned results match a reference model over 1000 random operands.
